mipi_link_sched: RTL and testbench

Link scheduler for the 4-lane MIPI DSI transmitter. It shares the HS data lanes between the video packetizer and a DCS command engine, and sequences each HS burst: LP-11 stop, LP-01 HS-request, LP-00 bridge, HS-zero, payload grant, HS-trail, LP-11 exit. It sits between the requesters and the HS/LP lane transmitter, and is gated by screen-init completion.

---
 rtl/mipi_link_sched.sv | 204 ++++++++++++++++++++
 tb/tb_mipi_link_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mipi_link_sched.sv
// rtl/mipi_link_sched.sv - HS burst sequencer and lane arbiter for the 4-lane DSI transmitter
module mipi_link_sched #(
    parameter int T_LPX      = 4,
    parameter int T_HS_PREP  = 3,
    parameter int T_HS_ZERO  = 6,
    parameter int T_HS_TRAIL = 5,
    parameter int T_HS_EXIT  = 8,
    parameter int GNT_MAX    = 4095
) (
    input  logic       I_lcd_clk,
    input  logic       I_rst_n,
    input  logic       I_init_done,
    input  logic       I_vid_vblank,
    input  logic       I_vid_req,
    output logic       O_vid_gnt,
    input  logic       I_vid_done,
    input  logic       I_cmd_req,
    output logic       O_cmd_gnt,
    input  logic       I_cmd_done,
    output logic [1:0] O_lane_sel,
    output logic [1:0] O_lp_state,
    output logic       O_hs_data_en,
    output logic       O_hs_zero,
    output logic       O_hs_trail,
    output logic       O_busy,
    output logic       O_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_RQST, S_BRDG, S_ZERO, S_GRANT, S_TRAIL, S_EXIT
    } state_t;

    localparam logic [7:0]  LPX_M1   = 8'(T_LPX - 1);
    localparam logic [7:0]  PREP_M1  = 8'(T_HS_PREP - 1);
    localparam logic [7:0]  ZERO_M1  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0]  TRAIL_M1 = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0]  EXIT_M1  = 8'(T_HS_EXIT - 1);
    localparam logic [15:0] GNT_M1   = 16'(GNT_MAX - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_VID  = 2'b01;
    localparam logic [1:0] OWN_CMD  = 2'b10;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [15:0] wdog, wdog_nxt;
    logic [1:0]  owner, owner_nxt;
    logic        timeout_nxt;
    logic        own_done;

    logic [1:0]  lp_nxt, lane_nxt;
    logic        hs_en_nxt, hs_zero_nxt, hs_trail_nxt;
    logic        vid_gnt_nxt, cmd_gnt_nxt, busy_nxt;

    // Only the latched owner's done ends the grant; the other requester's pulse is noise here.
    assign own_done = ((owner == OWN_VID) && I_vid_done) ||
                      ((owner == OWN_CMD) && I_cmd_done);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wdog_nxt    = wdog;
        owner_nxt   = owner;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_init_done) begin
                    if (I_vid_req) begin
                        owner_nxt = OWN_VID;
                        state_nxt = S_RQST;
                        cnt_nxt   = LPX_M1;
                    end else if (I_cmd_req && I_vid_vblank) begin
                        owner_nxt = OWN_CMD;
                        state_nxt = S_RQST;
                        cnt_nxt   = LPX_M1;
                    end
                end
            end
            S_RQST: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_BRDG;
                    cnt_nxt   = PREP_M1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_BRDG: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_ZERO;
                    cnt_nxt   = ZERO_M1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_ZERO: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_GRANT;
                    wdog_nxt  = 16'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_GRANT: begin
                // A done on the last allowed cycle wins over the watchdog.
                if (own_done) begin
                    state_nxt = S_TRAIL;
                    cnt_nxt   = TRAIL_M1;
                end else if (wdog == GNT_M1) begin
                    state_nxt   = S_TRAIL;
                    cnt_nxt     = TRAIL_M1;
                    timeout_nxt = 1'b1;
                end else begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            S_TRAIL: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_EXIT;
                    cnt_nxt   = EXIT_M1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_EXIT: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                    owner_nxt = OWN_NONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                owner_nxt = OWN_NONE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        lp_nxt       = 2'b11;
        lane_nxt     = OWN_NONE;
        hs_en_nxt    = 1'b0;
        hs_zero_nxt  = 1'b0;
        hs_trail_nxt = 1'b0;
        vid_gnt_nxt  = 1'b0;
        cmd_gnt_nxt  = 1'b0;
        busy_nxt     = (state_nxt != S_IDLE);
        case (state_nxt)
            S_RQST:  lp_nxt = 2'b01;
            S_BRDG:  lp_nxt = 2'b00;
            S_ZERO: begin
                hs_en_nxt   = 1'b1;
                hs_zero_nxt = 1'b1;
            end
            S_GRANT: begin
                hs_en_nxt   = 1'b1;
                lane_nxt    = owner_nxt;
                vid_gnt_nxt = (owner_nxt == OWN_VID);
                cmd_gnt_nxt = (owner_nxt == OWN_CMD);
            end
            S_TRAIL: begin
                hs_en_nxt    = 1'b1;
                hs_trail_nxt = 1'b1;
                lane_nxt     = owner_nxt;
            end
            default: lp_nxt = 2'b11;
        endcase
    end

    always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            wdog         <= 16'd0;
            owner        <= OWN_NONE;
            O_lp_state   <= 2'b11;
            O_lane_sel   <= OWN_NONE;
            O_hs_data_en <= 1'b0;
            O_hs_zero    <= 1'b0;
            O_hs_trail   <= 1'b0;
            O_vid_gnt    <= 1'b0;
            O_cmd_gnt    <= 1'b0;
            O_busy       <= 1'b0;
            O_timeout    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            wdog         <= wdog_nxt;
            owner        <= owner_nxt;
            O_lp_state   <= lp_nxt;
            O_lane_sel   <= lane_nxt;
            O_hs_data_en <= hs_en_nxt;
            O_hs_zero    <= hs_zero_nxt;
            O_hs_trail   <= hs_trail_nxt;
            O_vid_gnt    <= vid_gnt_nxt;
            O_cmd_gnt    <= cmd_gnt_nxt;
            O_busy       <= busy_nxt;
            O_timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mipi_link_sched.sv
// tb/tb_mipi_link_sched.sv - directed cycle-accurate bench for mipi_link_sched
module tb_mipi_link_sched;

    logic       I_lcd_clk;
    logic       I_rst_n;
    logic       I_init_done;
    logic       I_vid_vblank;
    logic       I_vid_req;
    logic       O_vid_gnt;
    logic       I_vid_done;
    logic       I_cmd_req;
    logic       O_cmd_gnt;
    logic       I_cmd_done;
    logic [1:0] O_lane_sel;
    logic [1:0] O_lp_state;
    logic       O_hs_data_en;
    logic       O_hs_zero;
    logic       O_hs_trail;
    logic       O_busy;
    logic       O_timeout;

    int n_chk = 0;
    int n_err = 0;

    // {lp, hs_en, zero, trail, vid_gnt, cmd_gnt, lane_sel, busy, timeout}
    localparam logic [10:0] RST_VEC = 11'b11_0_0_0_0_0_00_0_0;

    mipi_link_sched #(.GNT_MAX(16)) dut (
        .I_lcd_clk    (I_lcd_clk),
        .I_rst_n      (I_rst_n),
        .I_init_done  (I_init_done),
        .I_vid_vblank (I_vid_vblank),
        .I_vid_req    (I_vid_req),
        .O_vid_gnt    (O_vid_gnt),
        .I_vid_done   (I_vid_done),
        .I_cmd_req    (I_cmd_req),
        .O_cmd_gnt    (O_cmd_gnt),
        .I_cmd_done   (I_cmd_done),
        .O_lane_sel   (O_lane_sel),
        .O_lp_state   (O_lp_state),
        .O_hs_data_en (O_hs_data_en),
        .O_hs_zero    (O_hs_zero),
        .O_hs_trail   (O_hs_trail),
        .O_busy       (O_busy),
        .O_timeout    (O_timeout)
    );

    initial I_lcd_clk = 1'b0;
    always #5 I_lcd_clk = ~I_lcd_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {O_lp_state, O_hs_data_en, O_hs_zero, O_hs_trail, O_vid_gnt,
                O_cmd_gnt, O_lane_sel, O_busy, O_timeout};
    endfunction

    task automatic step();
        @(posedge I_lcd_clk);
        #1;
    endtask

    // Default timing: RQST 1-4, BRDG 5-7, ZERO 8-13, GRANT 14..gend, TRAIL 5, EXIT 8, then IDLE.
    function automatic logic [10:0] exp_vec(input int c, input int own, input int gend, input bit to);
        logic [1:0] lp, ls, lsc;
        logic en, z, t, vg, cg, bz, tm;
        lp = 2'b11; ls = 2'b00; en = 0; z = 0; t = 0; vg = 0; cg = 0; bz = 1; tm = 0;
        lsc = (own == 1) ? 2'b01 : 2'b10;
        if (c <= 4) lp = 2'b01;
        else if (c <= 7) lp = 2'b00;
        else if (c <= 13) begin en = 1; z = 1; end
        else if (c <= gend) begin
            en = 1; vg = (own == 1); cg = (own == 2); ls = lsc;
        end else if (c <= gend + 5) begin
            en = 1; t = 1; ls = lsc; tm = to && (c == gend + 1);
        end else if (c > gend + 13) bz = 0;
        return {lp, en, z, t, vg, cg, ls, bz, tm};
    endfunction

    // Entered in the IDLE cycle where the request is sampled (cycle 0); ends on the next IDLE cycle.
    task automatic burst(input int own, input int d, input int stray_at, input int vbl_drop_at);
        int gend;
        bit to;
        gend = (d < 0) ? 29 : d;
        to   = (d < 0);
        for (int c = 1; c <= gend + 14; c++) begin
            step();
            I_vid_done = 1'b0;
            I_cmd_done = 1'b0;
            chk($sformatf("burst_own%0d_c%0d", own, c), 32'(obs()), 32'(exp_vec(c, own, gend, to)));
            if (c == 14) begin
                if (own == 1) I_vid_req = 1'b0;
                else          I_cmd_req = 1'b0;
            end
            if (c == d) begin
                if (own == 1) I_vid_done = 1'b1;
                else          I_cmd_done = 1'b1;
            end
            if (c == stray_at) begin
                if (own == 1) I_cmd_done = 1'b1;
                else          I_vid_done = 1'b1;
            end
            if (c == vbl_drop_at) I_vid_vblank = 1'b0;
        end
    endtask

    initial begin
        logic bad;
        I_rst_n = 1'b0; I_init_done = 1'b0; I_vid_vblank = 1'b0;
        I_vid_req = 1'b0; I_vid_done = 1'b0; I_cmd_req = 1'b0; I_cmd_done = 1'b0;
        step();
        step();
        chk("reset_vals", 32'(obs()), 32'(RST_VEC));

        I_rst_n = 1'b1;
        I_vid_req = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs() !== RST_VEC) bad = 1'b1;
        end
        chk("no_init_no_grant", 32'(bad), 32'd0);

        I_init_done = 1'b1;
        burst(1, 20, -1, -1);

        I_cmd_req = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (O_cmd_gnt !== 1'b0 || O_busy !== 1'b0) bad = 1'b1;
        end
        chk("cmd_outside_vblank", 32'(bad), 32'd0);
        I_vid_vblank = 1'b1;
        burst(2, 20, -1, -1);
        I_vid_vblank = 1'b0;

        I_vid_req = 1'b1; I_cmd_req = 1'b1; I_vid_vblank = 1'b1;
        burst(1, 18, 16, -1);
        burst(2, 22, -1, 16);

        I_vid_req = 1'b1;
        burst(1, -1, 18, -1);

        I_vid_req = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk("rst_pre_grant", 32'(O_vid_gnt), 32'd1);
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'(RST_VEC));
        step();
        chk("rst_held", 32'(obs()), 32'(RST_VEC));
        I_rst_n = 1'b1;
        burst(1, 20, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
